// File: rtl/booth_seq_multiplier_if.sv
// Operand/result handshake bundle for booth_seq_multiplier.
//   in_valid/in_ready   : operand handshake (M, R, is_signed)
//   busy                : Booth iteration in progress
//   out_valid/out_ready : result handshake (RES)
// master = operand producer / result consumer, slave = the multiplier.
interface booth_seq_multiplier_if #(
    parameter int unsigned m_size = 8,
    parameter int unsigned r_size = 8
);
    localparam int unsigned res_size = m_size + r_size;

    logic                in_valid;
    logic                in_ready;
    logic [m_size-1:0]   M;
    logic [r_size-1:0]   R;
    logic                is_signed;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [res_size-1:0] RES;

    modport master (
        output in_valid, M, R, is_signed, out_ready,
        input  in_ready, busy, out_valid, RES
    );

    modport slave (
        input  in_valid, M, R, is_signed, out_ready,
        output in_ready, busy, out_valid, RES
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of booth_seq_multiplier_if: operands M/R/is_signed via
//          in_valid/in_ready, product RES via out_valid/out_ready, busy flag.
// A transaction takes r_size+1 steps after acceptance; RES holds in DONE until
// out_ready and keeps the last product after returning to IDLE.
module booth_seq_multiplier #(
    parameter int unsigned m_size = 8,
    parameter int unsigned r_size = 8
) (
    input logic                   clk,
    input logic                   rst,
    booth_seq_multiplier_if.slave bus
);
    localparam int unsigned res_size = m_size + r_size;
    localparam int unsigned p_size   = m_size + r_size + 3;
    localparam int unsigned cnt_size = $clog2(r_size + 2);
    localparam logic [cnt_size-1:0] last_step = cnt_size'(r_size);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [p_size-1:0]   p_q, p_d;
    logic [m_size:0]     a_q, a_d;
    logic [m_size:0]     s_q, s_d;
    logic [cnt_size-1:0] cnt_q, cnt_d;
    logic [res_size-1:0] res_q, res_d;

    logic [m_size:0]     m_ext;
    logic [r_size:0]     r_ext;
    logic [m_size:0]     upper;
    logic [m_size:0]     addend;
    logic [m_size:0]     upper_sum;
    logic [p_size-1:0]   p_shifted;

    // Operand extension and one Booth step (add/sub then arithmetic shift).
    // The extra top bit makes -M exact for the most-negative signed M.
    always_comb begin
        m_ext  = bus.is_signed ? {bus.M[m_size-1], bus.M} : {1'b0, bus.M};
        r_ext  = bus.is_signed ? {bus.R[r_size-1], bus.R} : {1'b0, bus.R};
        upper  = p_q[p_size-1 -: m_size+1];
        addend = '0;
        case (p_q[1:0])
            2'b01:   addend = a_q;
            2'b10:   addend = s_q;
            default: addend = '0;
        endcase
        upper_sum = upper + addend;
        p_shifted = {upper_sum[m_size], upper_sum, p_q[r_size+1:1]};
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        a_d     = a_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    p_d     = {{(m_size + 1){1'b0}}, r_ext, 1'b0};
                    a_d     = m_ext;
                    s_d     = -m_ext;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                p_d   = p_shifted;
                cnt_d = cnt_q + cnt_size'(1);
                if (cnt_q == last_step) begin
                    res_d   = p_shifted[res_size:1];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            a_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q == StBusy);
    assign bus.out_valid = (state_q == StDone);
    assign bus.RES       = res_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    booth_seq_multiplier_if #(.m_size(4), .r_size(4)) bus4 ();
    booth_seq_multiplier_if #(.m_size(8), .r_size(5)) bus8 ();

    booth_seq_multiplier #(.m_size(4), .r_size(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    booth_seq_multiplier #(.m_size(8), .r_size(5)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    typedef struct {
        logic [3:0] m;
        logic [3:0] r;
        logic       sgn;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands at a negedge; returns at #1 after the accepting edge.
    task automatic accept4(input logic [3:0] m, input logic [3:0] r, input logic sgn);
        int guard;
        @(negedge clk);
        bus4.M = m;
        bus4.R = r;
        bus4.is_signed = sgn;
        bus4.in_valid = 1'b1;
        guard = 0;
        while (!bus4.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus4.in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.M = ~m;
        bus4.R = ~r;
        bus4.is_signed = ~sgn;
    endtask

    // Counts edges after acceptance until out_valid is seen (bounded).
    task automatic wait_done4(output int n);
        n = 0;
        while (!bus4.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release4(input string name);
        @(negedge clk);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b0;
        check({name, "_ov_drop"}, 32'(bus4.out_valid), 32'd0);
        check({name, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
    endtask

    initial begin
        int         lat;
        int         guard;
        bit         ok;
        logic [7:0] held;

        vecs[0] = '{4'h8, 4'h8, 1'b1, 8'h40};
        vecs[1] = '{4'h8, 4'h7, 1'b1, 8'hC8};
        vecs[2] = '{4'h7, 4'hF, 1'b1, 8'hF9};
        vecs[3] = '{4'hF, 4'hF, 1'b0, 8'hE1};
        vecs[4] = '{4'h8, 4'h8, 1'b0, 8'h40};
        vecs[5] = '{4'h0, 4'hD, 1'b0, 8'h00};
        vecs[6] = '{4'hF, 4'h1, 1'b0, 8'h0F};
        vecs[7] = '{4'h0, 4'h8, 1'b1, 8'h00};

        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.M = '0; bus4.R = '0; bus4.is_signed = 1'b0;
        bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.M = '0; bus8.R = '0; bus8.is_signed = 1'b0;
        bus8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_res", 32'(bus4.RES), 32'd0);

        // Directed corner vectors, latency included.
        for (int i = 0; i < 8; i++) begin
            accept4(vecs[i].m, vecs[i].r, vecs[i].sgn);
            check($sformatf("vec%0d_busy", i), 32'(bus4.busy), 32'd1);
            wait_done4(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_res", i), 32'(bus4.RES), 32'(vecs[i].res));
            release4($sformatf("vec%0d", i));
        end

        // Backpressure: 6*5 unsigned held in DONE for 10 cycles.
        accept4(4'h6, 4'h5, 1'b0);
        wait_done4(lat);
        check("bp_res", 32'(bus4.RES), 32'h1E);
        held = bus4.RES;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!bus4.out_valid || bus4.in_ready || bus4.RES !== held) ok = 1'b0;
        end
        check("bp_hold_stable", 32'(ok), 32'd1);
        release4("bp");
        @(negedge clk);
        bus4.M = 4'h2; bus4.R = 4'h3; bus4.is_signed = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        check("bp_next_accept", 32'(bus4.busy), 32'd1);
        wait_done4(lat);
        check("bp_next_res", 32'(bus4.RES), 32'h06);
        release4("bp_next");

        // in_valid pulsed while busy must be ignored.
        accept4(4'h5, 4'hD, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus4.M = 4'h3; bus4.R = 4'h3; bus4.is_signed = 1'b0; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        wait_done4(lat);
        check("ign_res", 32'(bus4.RES), 32'hF1);
        release4("ign");
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus4.out_valid || bus4.busy) ok = 1'b0;
        end
        check("ign_single_result", 32'(ok), 32'd1);

        // Reset at step 2 of 7*7.
        accept4(4'h7, 4'h7, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_in_ready", 32'(bus4.in_ready), 32'd1);
        check("mrst_busy", 32'(bus4.busy), 32'd0);
        check("mrst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("mrst_res", 32'(bus4.RES), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus4.out_valid || bus4.busy) ok = 1'b0;
        end
        check("mrst_no_stale", 32'(ok), 32'd1);
        accept4(4'h3, 4'h3, 1'b0);
        wait_done4(lat);
        check("mrst_after_res", 32'(bus4.RES), 32'h09);
        release4("mrst_after");

        // Random sweep on the 8x5 instance against an integer reference product.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0]  m8;
            logic [4:0]  r8;
            logic        s8;
            int          a;
            int          b;
            int          prod;
            logic [12:0] exp13;
            logic [12:0] res_held;
            int          stall;
            m8 = 8'($urandom);
            r8 = 5'($urandom);
            s8 = 1'($urandom);
            a = s8 ? {{24{m8[7]}}, m8} : {24'd0, m8};
            b = s8 ? {{27{r8[4]}}, r8} : {27'd0, r8};
            prod = a * b;
            exp13 = prod[12:0];

            @(negedge clk);
            bus8.M = m8; bus8.R = r8; bus8.is_signed = s8; bus8.in_valid = 1'b1;
            guard = 0;
            while (!bus8.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            @(posedge clk);
            #1;
            bus8.in_valid = 1'b0;
            bus8.M = ~m8; bus8.R = ~r8; bus8.is_signed = ~s8;
            lat = 0;
            while (!bus8.out_valid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
            ok = (guard < 50) && (lat == 6);
            res_held = bus8.RES;
            stall = $urandom_range(0, 3);
            repeat (stall) begin
                @(posedge clk);
                #1;
                if (!bus8.out_valid || bus8.RES !== res_held) ok = 1'b0;
            end
            @(negedge clk);
            bus8.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus8.out_ready = 1'b0;
            if (bus8.out_valid || !bus8.in_ready) ok = 1'b0;
            check($sformatf("rnd%0d_res m=%0h r=%0h s=%0d", i, m8, r8, s8),
                  32'(res_held), 32'(exp13));
            check($sformatf("rnd%0d_handshake", i), 32'(ok), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Iterative radix-2 Booth multiplier that executes one Booth step per clock.
- Each transaction selects signed or unsigned operands.
- Operands are accepted and results returned through valid/ready handshakes.
- It replaces the flat combinational multiplier array where area matters more than latency, and sits between operand producers and accumulator/datapath consumers.

Parameters:
- m_size, default 8: multiplicand M width in bits; must be >= r_size.
- r_size, default 8: multiplier R width in bits; must be >= 2.
- res_size, default m_size + r_size: product width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands M, R, is_signed are valid.
- in_ready  output  1  block can accept operands.
- M  input  m_size  multiplicand.
- R  input  r_size  multiplier.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
- busy  output  1  a Booth iteration is in progress.
- out_valid  output  1  RES holds a completed product.
- out_ready  input  1  consumer takes RES.
- RES  output  res_size  product, registered.

Behaviour:
- Reset:
  - rst sampled high at a rising edge forces state IDLE.
  - in_ready=1, busy=0, out_valid=0, RES=0. The internal P register and the step counter clear.
  - Reset takes priority over every other event, including mid-BUSY and DONE; any in-flight transaction is discarded.
- States are IDLE, BUSY and DONE.
  - in_ready = (state==IDLE).
  - busy = (state==BUSY).
  - out_valid = (state==DONE).
- IDLE, on in_valid=1 at an edge (acceptance):
  - Extend M to m_size+1 bits: sign-extend if is_signed, else zero-extend. The same rule applies to R at r_size+1 bits.
  - Load P = {(m_size+1) zeros, R_ext, 1'b0}. P is m_size+r_size+3 bits.
  - Latch A = M_ext and S = -M_ext, both m_size+1 bits. The extra bit makes negation of the most-negative M exact.
  - Clear the counter and go to BUSY.
- BUSY, each cycle, one Booth step on the low two bits of P:
  - P[1:0]==01: add A to the upper m_size+1 bits of P.
  - P[1:0]==10: add S to the upper m_size+1 bits of P.
  - 00 or 11: no add.
  - Then arithmetic-shift P right by 1, replicating the MSB.
  - Additions wrap modulo 2^(m_size+1) within the upper field.
  - After exactly r_size+1 steps: RES <= P[res_size:1], state <= DONE.
- Latency:
  - Acceptance at edge t0, steps at edges t0+1 through t0+r_size+1.
  - out_valid is high in the cycle after edge t0+r_size+1.
- Result rule:
  - RES equals the exact product modulo 2^res_size.
  - The product always fits res_size bits in both modes, so there is no truncation.
- DONE:
  - RES and out_valid hold stable until out_ready=1 at an edge.
  - On that edge go to IDLE, with out_valid=0 the next cycle.
  - in_ready stays 0 in DONE. A new acceptance is possible at the earliest on the edge after the out_ready handshake, so throughput is one product per r_size+3 cycles.
- Ignored inputs:
  - in_valid while BUSY or DONE is ignored and has no effect on the transaction.
  - M, R and is_signed are don't-care except at the acceptance edge.
  - out_ready outside DONE is ignored.
- Zero operands:
  - M=0 or R=0 gives RES=0 with the normal latency. There is no early termination.
- RES retains the last product after returning to IDLE, until the next DONE or reset.

Test Plan:
1. Signed corners, m_size=r_size=4:
   - (-8)*(-8) -> RES=0x40.
   - (-8)*7 -> RES=0xC8.
   - 7*(-1) -> RES=0xF9.
   - In each case out_valid rises exactly r_size+2=6 cycles after the cycle in which in_valid and in_ready were both high.
2. Unsigned corners, 4x4, is_signed=0:
   - 15*15 -> RES=0xE1.
   - 8*8 -> RES=0x40.
   - 0*13 -> RES=0x00.
   - 15*1 -> RES=0x0F.
3. Backpressure:
   - Hold out_ready=0 for 10 cycles in DONE -> out_valid and RES stay stable and in_ready stays 0.
   - Raise out_ready -> IDLE next cycle; a new operand is accepted on the following edge.
4. Ignored input:
   - Pulse in_valid with M=3, R=3 while BUSY on 5*(-3) signed -> RES=0xF1 for the original operands only, and exactly one result is produced.
5. Reset mid-operation:
   - Assert rst for 1 cycle at step 2 of a transaction -> in_ready=1, busy=0, out_valid=0, RES=0 next cycle and no stale result appears.
   - Then run 3*3 -> RES=0x09.
6. Randomised sweep at m_size=8, r_size=5:
   - Run 2000 random operands with random is_signed and random out_ready stalls.
   - Compare each RES to a reference product mod 2^13; no mismatches and no lost or duplicated results.
